// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: output-side packetizer of the leaf interface.
// Round-robin arbitrates user output streams, stamps each accepted word with
// its configured destination leaf/port and write address, and tracks
// per-port credit against the destination's freespace.
module leaf_out_arbiter #(
   parameter int PACKET_BITS   = 49,
   parameter int PAYLOAD_BITS  = 32,
   parameter int NUM_LEAF_BITS = 5,
   parameter int NUM_PORT_BITS = 4,
   parameter int NUM_ADDR_BITS = 7,
   parameter int NUM_OUT_PORTS = 7
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
   input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
   output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
   input  logic                                    cfg_wr,
   input  logic [NUM_PORT_BITS-1:0]                cfg_port,
   input  logic [NUM_LEAF_BITS-1:0]                cfg_dest_leaf,
   input  logic [NUM_PORT_BITS-1:0]                cfg_dest_port,
   input  logic                                    credit_vld,
   input  logic [NUM_PORT_BITS-1:0]                credit_port,
   input  logic [NUM_ADDR_BITS:0]                  credit_amount,
   input  logic                                    resend,
   output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft
);

   localparam int CW    = NUM_ADDR_BITS + 1;
   localparam int PTR_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
   // One extra bit of headroom so credit + amount cannot overflow before saturation.
   localparam logic [CW:0] CREDIT_MAX = {1'b0, 1'b1, {NUM_ADDR_BITS{1'b0}}};

   logic                     cfg_valid [NUM_OUT_PORTS];
   logic [NUM_LEAF_BITS-1:0] dest_leaf [NUM_OUT_PORTS];
   logic [NUM_PORT_BITS-1:0] dest_port [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0] wr_addr   [NUM_OUT_PORTS];
   logic [CW-1:0]            credit    [NUM_OUT_PORTS];
   logic [CW:0]              credit_sum[NUM_OUT_PORTS];
   logic [CW-1:0]            credit_next[NUM_OUT_PORTS];

   logic [PTR_W-1:0]         rr_ptr;
   logic [NUM_OUT_PORTS-1:0] eligible;
   logic [NUM_OUT_PORTS-1:0] port_grant;
   logic                     grant_vld;
   logic [PTR_W-1:0]         grant_idx;
   logic [PAYLOAD_BITS-1:0]  grant_payload;

   // Per-port eligibility: valid word, configured, credit left, not stalled.
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
         eligible[i] = vld_user2interface[i] && cfg_valid[i] && (credit[i] != '0)
                       && !resend && !reset;
      end
   end

   // Round-robin search starting one past the last granted port.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int unsigned k = 1; k <= NUM_OUT_PORTS; k++) begin
         int unsigned idx;
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_OUT_PORTS) idx = idx - NUM_OUT_PORTS;
         if (!grant_vld && eligible[PTR_W'(idx)]) begin
            grant_vld = 1'b1;
            grant_idx = PTR_W'(idx);
         end
      end
   end

   // One-hot grant, driven back to the user as ack.
   always_comb begin
      port_grant = '0;
      if (grant_vld) port_grant[grant_idx] = 1'b1;
      ack_interface2user = port_grant;
      grant_payload = din_leaf_user2interface[grant_idx*PAYLOAD_BITS +: PAYLOAD_BITS];
   end

   // Next credit: minus one on grant, plus any freed words, saturated.
   always_comb begin
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
         credit_sum[i] = {1'b0, credit[i]} - {{CW{1'b0}}, port_grant[i]};
         if (credit_vld && credit_port == NUM_PORT_BITS'(i))
            credit_sum[i] = credit_sum[i] + {1'b0, credit_amount};
         if (credit_sum[i] > CREDIT_MAX) credit_sum[i] = CREDIT_MAX;
         credit_next[i] = credit_sum[i][CW-1:0];
      end
   end

   // Registered packet output and per-port state update.
   always_ff @(posedge clk) begin
      if (reset) begin
         dout_leaf_interface2bft <= '0;
         rr_ptr <= PTR_W'(NUM_OUT_PORTS - 1);
         for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            cfg_valid[i] <= 1'b0;
            dest_leaf[i] <= '0;
            dest_port[i] <= '0;
            wr_addr[i]   <= '0;
            credit[i]    <= CREDIT_MAX[CW-1:0];
         end
      end else begin
         if (grant_vld) begin
            dout_leaf_interface2bft <= {1'b1, dest_leaf[grant_idx], dest_port[grant_idx],
                                        wr_addr[grant_idx], grant_payload};
            rr_ptr <= grant_idx;
         end else begin
            dout_leaf_interface2bft <= '0;
         end
         for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            // Grant reads the old destination; a same-cycle write lands afterwards.
            if (cfg_wr && cfg_port == NUM_PORT_BITS'(i)) begin
               cfg_valid[i] <= 1'b1;
               dest_leaf[i] <= cfg_dest_leaf;
               dest_port[i] <= cfg_dest_port;
            end
            if (port_grant[i]) wr_addr[i] <= wr_addr[i] + 1'b1;
            credit[i] <= credit_next[i];
         end
      end
   end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Testbench for leaf_out_arbiter: vector table plus hand-written corner-case
// sequences, with expected packets queued when stimulus is driven.
module tb_leaf_out_arbiter;

   localparam int N = 7;

   logic           clk;
   logic           reset;
   logic [N*32-1:0] din;
   logic [N-1:0]   vld;
   logic [N-1:0]   ack;
   logic           cfg_wr;
   logic [3:0]     cfg_port;
   logic [4:0]     cfg_dest_leaf;
   logic [3:0]     cfg_dest_port;
   logic           credit_vld;
   logic [3:0]     credit_port;
   logic [7:0]     credit_amount;
   logic           resend;
   logic [48:0]    dout;

   leaf_out_arbiter #(
      .PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_LEAF_BITS(5),
      .NUM_PORT_BITS(4), .NUM_ADDR_BITS(7), .NUM_OUT_PORTS(N)
   ) dut (
      .clk(clk), .reset(reset),
      .din_leaf_user2interface(din), .vld_user2interface(vld),
      .ack_interface2user(ack),
      .cfg_wr(cfg_wr), .cfg_port(cfg_port), .cfg_dest_leaf(cfg_dest_leaf),
      .cfg_dest_port(cfg_dest_port),
      .credit_vld(credit_vld), .credit_port(credit_port), .credit_amount(credit_amount),
      .resend(resend), .dout_leaf_interface2bft(dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] v;
      logic         rs;
      logic [31:0]  pay;
      logic [N-1:0] exp_ack;
   } vec_t;

   vec_t        vecs[$];
   logic [48:0] exp_q[$];
   logic [4:0]  m_leaf[N];
   logic [3:0]  m_port[N];
   logic [6:0]  m_addr[N];
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, expv);
      end
   endtask

   task automatic set_din(input logic [31:0] pay);
      for (int i = 0; i < N; i++) din[i*32 +: 32] = pay ^ (32'(i) << 24);
   endtask

   // Inputs already driven: check ack, queue expected packet, clock, check output.
   task automatic cycle(input logic [N-1:0] exp_ack, input string name);
      logic [48:0] pkt;
      #1;
      chk({name, "_ack"}, 64'(ack), 64'(exp_ack));
      pkt = '0;
      for (int i = 0; i < N; i++) begin
         if (exp_ack[i]) begin
            pkt = {1'b1, m_leaf[i], m_port[i], m_addr[i], din[i*32 +: 32]};
            m_addr[i] = m_addr[i] + 7'd1;
         end
      end
      exp_q.push_back(pkt);
      @(posedge clk);
      #1;
      chk({name, "_dout"}, 64'(dout), 64'(exp_q.pop_front()));
   endtask

   task automatic cfg(input int p, input logic [4:0] l, input logic [3:0] d);
      vld = '0;
      cfg_wr = 1'b1;
      cfg_port = 4'(p);
      cfg_dest_leaf = l;
      cfg_dest_port = d;
      cycle('0, "cfg");
      cfg_wr = 1'b0;
      if (p < N) begin
         m_leaf[p] = l;
         m_port[p] = d;
      end
   endtask

   task automatic add(input logic [N-1:0] v, input logic rs, input logic [31:0] pay,
                      input logic [N-1:0] e);
      vec_t t;
      t.v = v; t.rs = rs; t.pay = pay; t.exp_ack = e;
      vecs.push_back(t);
   endtask

   initial begin
      reset = 1'b1; vld = '0; din = '0; resend = 1'b0;
      cfg_wr = 1'b0; cfg_port = '0; cfg_dest_leaf = '0; cfg_dest_port = '0;
      credit_vld = 1'b0; credit_port = '0; credit_amount = '0;
      for (int i = 0; i < N; i++) begin
         m_leaf[i] = '0; m_port[i] = '0; m_addr[i] = '0;
      end

      // Vector table: single port, round robin, unconfigured, resend, mixed.
      for (int i = 0; i < 5; i++) add(7'h01, 1'b0, 32'hA0 + 32'(i), 7'h01);
      add(7'h07, 0, 32'h100, 7'h02); add(7'h07, 0, 32'h101, 7'h04);
      add(7'h07, 0, 32'h102, 7'h01); add(7'h07, 0, 32'h103, 7'h02);
      add(7'h07, 0, 32'h104, 7'h04); add(7'h07, 0, 32'h105, 7'h01);
      add(7'h10, 0, 32'h200, 7'h00); add(7'h11, 0, 32'h201, 7'h01);
      add(7'h01, 1, 32'h300, 7'h00); add(7'h01, 1, 32'h301, 7'h00);
      add(7'h01, 1, 32'h302, 7'h00); add(7'h01, 0, 32'h303, 7'h01);
      add(7'h78, 0, 32'h400, 7'h00);
      add(7'h05, 0, 32'h500, 7'h04); add(7'h05, 0, 32'h501, 7'h01);
      add(7'h06, 0, 32'h502, 7'h02); add(7'h06, 0, 32'h503, 7'h04);
      add(7'h03, 0, 32'h504, 7'h01); add(7'h00, 0, 32'h505, 7'h00);

      // Reset state
      cycle('0, "rst");
      vld = '1;
      cycle('0, "rst_vld");
      reset = 1'b0;
      vld = '0;

      cfg(0, 5'd3, 4'd2);
      cfg(1, 5'd5, 4'd1);
      cfg(2, 5'd7, 4'd3);

      foreach (vecs[k]) begin
         vld = vecs[k].v;
         resend = vecs[k].rs;
         set_din(vecs[k].pay);
         cycle(vecs[k].exp_ack, $sformatf("vec%0d", k));
      end
      vld = '0; resend = 1'b0;

      // Out-of-range config writes must not alias onto ports 1 or 4
      cfg(9, 5'd31, 4'd15);
      cfg(12, 5'd31, 4'd15);
      vld = 7'h10; set_din(32'h600);
      cycle('0, "oor_p4");
      vld = 7'h02;
      cycle(7'h02, "oor_p1");

      // Config write coinciding with grant: old destination used this cycle
      cfg_wr = 1'b1; cfg_port = 4'd1; cfg_dest_leaf = 5'd20; cfg_dest_port = 4'd9;
      set_din(32'h700);
      cycle(7'h02, "cfg_grant");
      cfg_wr = 1'b0;
      m_leaf[1] = 5'd20; m_port[1] = 4'd9;
      set_din(32'h701);
      cycle(7'h02, "cfg_new");
      vld = '0;

      // Credit exhaustion on port 5, then refill of 64
      cfg(5, 5'd9, 4'd6);
      vld = 7'h20;
      for (int i = 0; i < 128; i++) begin
         set_din(32'hC000 + 32'(i));
         cycle(7'h20, "drain");
      end
      cycle('0, "credit_empty0");
      cycle('0, "credit_empty1");
      credit_vld = 1'b1; credit_port = 4'd5; credit_amount = 8'd64;
      cycle('0, "credit_upd");
      credit_vld = 1'b0;
      set_din(32'hD000);
      cycle(7'h20, "credit_wrap");
      for (int i = 0; i < 62; i++) cycle(7'h20, "drain2");
      // Credit is 1: grant and +5 in the same cycle leaves 5
      credit_vld = 1'b1; credit_amount = 8'd5;
      cycle(7'h20, "coincide");
      credit_vld = 1'b0;
      for (int i = 0; i < 5; i++) cycle(7'h20, "coincide_left");
      cycle('0, "coincide_empty");
      vld = '0;

      // Saturation at 128 on port 6
      cfg(6, 5'd1, 4'd1);
      credit_vld = 1'b1; credit_port = 4'd6; credit_amount = 8'd100;
      cycle('0, "sat_upd");
      credit_vld = 1'b0;
      vld = 7'h40;
      for (int i = 0; i < 128; i++) cycle(7'h40, "sat_drain");
      cycle('0, "sat_empty");
      vld = '0;

      // Reset mid-stream
      vld = 7'h01; set_din(32'hE000);
      cycle(7'h01, "pre_rst");
      reset = 1'b1;
      cycle('0, "rst_mid");
      reset = 1'b0;
      for (int i = 0; i < N; i++) m_addr[i] = '0;
      cycle('0, "post_rst_unconf");
      vld = '0;
      cfg(0, 5'd3, 4'd2);
      cfg(1, 5'd5, 4'd1);
      cfg(5, 5'd9, 4'd6);
      vld = 7'h23; set_din(32'hF000);
      cycle(7'h01, "post_rst_rr0");
      vld = 7'h20;
      cycle(7'h20, "post_rst_credit");
      vld = '0;
      cycle('0, "idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/leaf_out_arbiter.md
# leaf_out_arbiter

Output-side packetizer of the leaf interface: it sits between the user-kernel output streams (`din_leaf_user2interface_*` / `vld_user2interface_*` / `ack_interface2user_*`) and the 49-bit BFT injection port. It round-robin arbitrates among up to `NUM_OUT_PORTS` 32-bit user streams and stamps each accepted word with its configured destination leaf, port and write address. It enforces per-port credit flow control against the destination's freespace and emits at most one packet per cycle toward the BFT.

## Interface
- `PACKET_BITS`, 49, BFT packet width; equals 1 + `NUM_LEAF_BITS` + `NUM_PORT_BITS` + `NUM_ADDR_BITS` + `PAYLOAD_BITS`.
- `PAYLOAD_BITS`, 32, user word width.
- `NUM_LEAF_BITS`, 5, destination leaf field width.
- `NUM_PORT_BITS`, 4, destination port field width.
- `NUM_ADDR_BITS`, 7, destination BRAM address field width; credit window is 2^`NUM_ADDR_BITS` words.
- `NUM_OUT_PORTS`, 7, number of user output streams (1..2^`NUM_PORT_BITS`).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `din_leaf_user2interface`  in  `NUM_OUT_PORTS`*`PAYLOAD_BITS`  user words; port i at bits [i*32 +: 32].
- `vld_user2interface`  in  `NUM_OUT_PORTS`  per-port word valid.
- `ack_interface2user`  out  `NUM_OUT_PORTS`  per-port accept; a transfer occurs when vld[i] && ack[i].
- `cfg_wr`  in  1  configuration write strobe.
- `cfg_port`  in  `NUM_PORT_BITS`  output port being configured.
- `cfg_dest_leaf`  in  `NUM_LEAF_BITS`  destination leaf for that port.
- `cfg_dest_port`  in  `NUM_PORT_BITS`  destination input port for that port.
- `credit_vld`  in  1  freespace update strobe.
- `credit_port`  in  `NUM_PORT_BITS`  output port receiving credit.
- `credit_amount`  in  `NUM_ADDR_BITS`+1  words freed at destination.
- `resend`  in  1  stall: no grants while high.
- `dout_leaf_interface2bft`  out  `PACKET_BITS`  registered packet; zero when idle.

## Operation
- **Packet format (MSB→LSB):** [48] valid, [47:43] dest leaf, [42:39] dest port, [38:32] addr, [31:0] payload.
- **Per-port state:**
  - `cfg_valid` (reset 0).
  - `dest_leaf` / `dest_port` (reset 0).
  - `wr_addr` (`NUM_ADDR_BITS`, reset 0).
  - `credit` (`NUM_ADDR_BITS`+1, reset 2^`NUM_ADDR_BITS` = 128).
- **Config:** `cfg_wr` writes dest fields and sets `cfg_valid` for `cfg_port`. `cfg_port` ≥ `NUM_OUT_PORTS` is ignored. Reconfiguring does not reset `wr_addr` or `credit`.
- **Eligibility:** port i is eligible when vld[i] && `cfg_valid`[i] && credit[i] != 0 && !resend && !reset.
- **Arbitration:** round-robin. Search starts at `rr_ptr`+1 and wraps modulo `NUM_OUT_PORTS`; the first eligible port wins. `rr_ptr` resets to `NUM_OUT_PORTS`-1, so port 0 has first priority, and updates to the granted index only on a grant.
- **Grant:** ack[i] is high combinationally for the single granted port only. All other acks are 0. Ack is never high without vld.
- **On a grant:**
  - Register packet {1, dest_leaf[i], dest_port[i], wr_addr[i], payload[i]}.
  - wr_addr[i] increments, wrapping 127→0.
  - credit[i] decrements.
- **No grant:** the output register loads all zeros.
- **Credit update:** credit[credit_port] += credit_amount, saturating at 128. Updates addressed to out-of-range ports are ignored.
- **Simultaneous grant and update on the same port:** new credit = min(128, credit − 1 + credit_amount). Both take effect in one cycle.
- **Simultaneous `cfg_wr` and grant on the same port:** the grant uses the old destination; the new destination applies from the next cycle.

## Timing
- Ack is combinational from vld, state and resend in the same cycle. The packet appears on `dout_leaf_interface2bft` on the next edge, so latency is 1 cycle.
- Sustained throughput is one packet per cycle in aggregate. A single port can stream back-to-back while it is the only eligible port.
- **resend:** acks drop in the same cycle. The output is 0 from the next edge. No state changes other than credit updates and config writes.
- **reset:** takes effect on the edge where it is sampled. From that edge, output = 0, all acks = 0 and all state returns to its reset values. Any in-flight grant in the reset cycle is discarded, with no ack.
- **Credit exhausted** (credit = 0): the port is ineligible until an update arrives. An update in cycle N makes the port grantable in cycle N+1.

## Test plan
- **Single port:** configure port 0 → leaf 3 / port 2. Send words 0xA0..0xA4 back-to-back → 5 consecutive packets, valid=1, leaf=3, port=2, addr 0..4, payloads in order, latency 1.
- **Round-robin:** ports 0, 1, 2 configured, all vld held high → grant order 0, 1, 2, 0, 1, 2. Exactly one ack per cycle.
- **Credit stall:** port 0 sends 128 words → addr wraps from 127 to 0 on word 129 only after `credit_amount`=64 is applied. With no update, ack stays 0 after word 128.
- **Update coinciding with grant:** credit=1, grant plus `credit_amount`=5 in the same cycle → credit=5.
- **Unconfigured and out-of-range:** vld on an unconfigured port 4 → never acked. `cfg_wr` with `cfg_port`=9 → no state change.
- **Mid-stream stalls:** resend pulse for 3 cycles mid-stream → 3 zero output packets and no address skips. Reset mid-stream → output 0, wr_addr=0, credit=128, `cfg_valid`=0.
